// File: rtl/zfsoc_led_blink_pio.sv
// ============================================================================
// Module   : zfsoc_led_blink_pio
// Brief    : Avalon-MM LED output port with atomic set/clear and hardware
//            blink mask driven by a programmable prescaler.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module zfsoc_led_blink_pio #(
  parameter int               WIDTH       = 10,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int               CNT_W       = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  localparam logic [1:0]       c_ADDR_DATA   = 2'd0;
  localparam logic [1:0]       c_ADDR_MASK   = 2'd1;
  localparam logic [1:0]       c_ADDR_PERIOD = 2'd2;
  localparam logic [1:0]       c_ADDR_SETCLR = 2'd3;
  localparam logic [CNT_W-1:0] c_CNT_ONE     = CNT_W'(1);

  logic [WIDTH-1:0] r_data;
  logic [WIDTH-1:0] r_mask;
  logic [CNT_W-1:0] r_period;
  logic [CNT_W-1:0] r_cnt;
  logic             r_phase;

  logic             w_wr;
  logic [WIDTH-1:0] w_set;
  logic [WIDTH-1:0] w_clr;
  logic [31:0]      w_rd_mux;
  logic             w_unused;

  assign w_wr     = chipselect & ~write_n;
  assign w_set    = writedata[WIDTH-1:0];
  assign w_clr    = writedata[16+WIDTH-1:16];
  assign w_unused = ^writedata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data <= RESET_VALUE;
      r_mask <= '0;
    end else if (w_wr) begin
      case (address)
        c_ADDR_DATA:   r_data <= writedata[WIDTH-1:0];
        c_ADDR_MASK:   r_mask <= writedata[WIDTH-1:0];
        // clear is applied last so it wins over a simultaneous set
        c_ADDR_SETCLR: r_data <= (r_data | w_set) & ~w_clr;
        default:       ;
      endcase
    end
  end

  // A PERIOD write outranks a terminal count: the blink restarts from phase 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_period <= '0;
      r_cnt    <= '0;
      r_phase  <= 1'b0;
    end else if (w_wr && (address == c_ADDR_PERIOD)) begin
      r_period <= writedata[CNT_W-1:0];
      r_cnt    <= '0;
      r_phase  <= 1'b0;
    end else if (r_period == '0) begin
      r_cnt    <= '0;
      r_phase  <= 1'b0;
    end else if (r_cnt == (r_period - c_CNT_ONE)) begin
      r_cnt    <= '0;
      r_phase  <= ~r_phase;
    end else begin
      r_cnt    <= r_cnt + c_CNT_ONE;
    end
  end

  always_comb begin
    w_rd_mux = '0;
    case (address)
      c_ADDR_DATA:   w_rd_mux[WIDTH-1:0] = r_data;
      c_ADDR_MASK:   w_rd_mux[WIDTH-1:0] = r_mask;
      c_ADDR_PERIOD: w_rd_mux[CNT_W-1:0] = r_period;
      default:       w_rd_mux[0]         = r_phase;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      readdata <= '0;
      out_port <= RESET_VALUE;
    end else begin
      readdata <= w_rd_mux;
      out_port <= r_data ^ (r_mask & {WIDTH{r_phase}});
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_zfsoc_led_blink_pio.sv
// ============================================================================
// Module   : tb_zfsoc_led_blink_pio
// Brief    : Directed self-checking bench for zfsoc_led_blink_pio.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_zfsoc_led_blink_pio;

  localparam int               WIDTH = 10;
  localparam logic [WIDTH-1:0] c_RST = 10'h2A5;

  logic             clk = 1'b0;
  logic             reset;
  logic [1:0]       address;
  logic             chipselect;
  logic             write_n;
  logic [31:0]      writedata;
  logic [31:0]      readdata;
  logic [WIDTH-1:0] out_port;

  int n_vec = 0;
  int n_err = 0;

  zfsoc_led_blink_pio #(
    .WIDTH       (WIDTH),
    .RESET_VALUE (c_RST),
    .CNT_W       (24)
  ) u_dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port)
  );

  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; the write lands on the next posedge.
  task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic bus_rd(input logic [1:0] a, output logic [31:0] d);
    address = a;
    @(negedge clk);
    d = readdata;
  endtask

  logic [31:0] rd;

  initial begin
    reset      = 1'b1;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;

    #2;
    check_vec("rst_out", 32'(out_port), 32'(c_RST));
    check_vec("rst_rd", readdata, 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    bus_rd(2'd0, rd); check_vec("rst_data", rd, 32'h2A5);
    bus_rd(2'd1, rd); check_vec("rst_mask", rd, 32'h0);
    bus_rd(2'd2, rd); check_vec("rst_period", rd, 32'h0);
    bus_rd(2'd3, rd); check_vec("rst_phase", rd, 32'h0);

    // set bit 2, clear bits 0 and 9
    bus_wr(2'd0, 32'h3FF);
    bus_wr(2'd3, 32'h0201_0004);
    check_vec("sc_out_old", 32'(out_port), 32'h3FF);
    @(negedge clk);
    check_vec("sc_out_new", 32'(out_port), 32'h1FE);
    bus_rd(2'd0, rd); check_vec("sc_data", rd, 32'h1FE);

    bus_wr(2'd0, 32'h0);
    bus_wr(2'd3, 32'h0008_0008);
    bus_rd(2'd0, rd); check_vec("sc_clr_wins", rd, 32'h0);

    // same-cycle write and read returns the pre-write value
    bus_wr(2'd1, 32'h155);
    check_vec("rd_pre_write", readdata, 32'h0);
    bus_rd(2'd1, rd); check_vec("rd_post_write", rd, 32'h155);

    // blink: DATA=F, MASK=3, PERIOD=4 -> 0xF / 0xC every 4 clocks
    bus_wr(2'd0, 32'h00F);
    bus_wr(2'd1, 32'h003);
    bus_wr(2'd2, 32'd4);
    address = 2'd3;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      check_vec($sformatf("blink_out_%0d", i), 32'(out_port),
                (((i - 1) / 4) % 2 == 1) ? 32'h00C : 32'h00F);
      check_vec($sformatf("blink_phase_%0d", i), readdata,
                32'(((i - 1) / 4) % 2));
    end
    bus_wr(2'd2, 32'd0);
    check_vec("p0_out_hold", 32'(out_port), 32'h00C);
    @(negedge clk);
    check_vec("p0_out", 32'(out_port), 32'h00F);
    bus_rd(2'd3, rd); check_vec("p0_phase", rd, 32'h0);
    repeat (5) @(negedge clk);
    check_vec("p0_static", 32'(out_port), 32'h00F);

    // period 1: bit 0 toggles every clock
    bus_wr(2'd0, 32'h0);
    bus_wr(2'd1, 32'h1);
    bus_wr(2'd2, 32'd1);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      check_vec($sformatf("p1_out_%0d", i), 32'(out_port), 32'((i - 1) % 2));
    end
    // this write coincides with a terminal count that would set phase to 1
    bus_wr(2'd2, 32'd1);
    @(negedge clk);
    check_vec("tc_no_toggle", 32'(out_port), 32'h0);
    @(negedge clk);
    check_vec("tc_restart", 32'(out_port), 32'h1);

    // asynchronous reset mid-blink
    bus_wr(2'd0, 32'h0);
    bus_wr(2'd1, 32'h3FF);
    bus_wr(2'd2, 32'd2);
    repeat (3) @(negedge clk);
    check_vec("ar_blinking", 32'(out_port), 32'h3FF);
    #2;
    reset = 1'b1;
    #1;
    check_vec("ar_out", 32'(out_port), 32'(c_RST));
    check_vec("ar_rd", readdata, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    check_vec("ar_no_blink", 32'(out_port), 32'(c_RST));
    bus_rd(2'd2, rd); check_vec("ar_period", rd, 32'h0);
    bus_rd(2'd1, rd); check_vec("ar_mask", rd, 32'h0);
    bus_rd(2'd0, rd); check_vec("ar_data", rd, 32'h2A5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
